// File: rtl/instr_mem_loader.sv
// Streams program bytes into the instruction memory as big-endian 32-bit words,
// zero-padding the final word and holding the CPU stalled until the image is in place.
module instr_mem_loader #(
   parameter int MEM_SIZE = 1024,
   parameter int ADDR_W   = $clog2(MEM_SIZE)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              cpu_hold,
   output logic              padded,
   output logic [15:0]       byte_count,
   output logic [7:0]        checksum
);

   typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_SIZE - 4);

   state_t            state_q, state_d;
   logic [1:0]        offset_q, offset_d;
   logic [ADDR_W-1:0] wordAddr_q, wordAddr_d;
   logic [31:0]       wordBuf_q, wordBuf_d;
   logic              memWe_q, memWe_d;
   logic [ADDR_W-1:0] memAddr_q, memAddr_d;
   logic [31:0]       memData_q, memData_d;
   logic              padded_q, padded_d;
   logic [15:0]       count_q, count_d;
   logic [7:0]        sum_q, sum_d;

   logic              accept;
   logic [4:0]        shiftAmt;
   logic [31:0]       wordNext;

   // Clearing the buffer at offset 0 means bytes after the current offset are
   // always zero, so a short final word is padded with NOPs for free.
   assign accept   = in_valid && (state_q == LOAD);
   assign shiftAmt = {2'd3 - offset_q, 3'b000};
   assign wordNext = ((offset_q == 2'd0) ? 32'h0 : wordBuf_q) | ({24'h0, in_data} << shiftAmt);

   always_comb begin
      state_d    = state_q;
      offset_d   = offset_q;
      wordAddr_d = wordAddr_q;
      wordBuf_d  = wordBuf_q;
      memWe_d    = 1'b0;
      memAddr_d  = memAddr_q;
      memData_d  = memData_q;
      padded_d   = padded_q;
      count_d    = count_q;
      sum_d      = sum_q;
      case (state_q)
         IDLE, DONE, ERROR: begin
            if (start) begin
               state_d    = LOAD;
               offset_d   = 2'd0;
               wordAddr_d = '0;
               count_d    = 16'd0;
               sum_d      = 8'd0;
               padded_d   = 1'b0;
            end
         end
         LOAD: begin
            if (accept) begin
               count_d   = count_q + 16'd1;
               sum_d     = sum_q + in_data;
               wordBuf_d = wordNext;
               offset_d  = offset_q + 2'd1;
               if (offset_q == 2'd3 || in_last) begin
                  memWe_d    = 1'b1;
                  memAddr_d  = wordAddr_q;
                  memData_d  = wordNext;
                  wordAddr_d = wordAddr_q + ADDR_W'(4);
                  offset_d   = 2'd0;
                  if (in_last) begin
                     state_d  = DONE;
                     padded_d = (offset_q != 2'd3);
                  end else if (wordAddr_q == LAST_ADDR) begin
                     state_d = ERROR;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         offset_q   <= 2'd0;
         wordAddr_q <= '0;
         wordBuf_q  <= 32'h0;
         memWe_q    <= 1'b0;
         memAddr_q  <= '0;
         memData_q  <= 32'h0;
         padded_q   <= 1'b0;
         count_q    <= 16'd0;
         sum_q      <= 8'd0;
      end else begin
         state_q    <= state_d;
         offset_q   <= offset_d;
         wordAddr_q <= wordAddr_d;
         wordBuf_q  <= wordBuf_d;
         memWe_q    <= memWe_d;
         memAddr_q  <= memAddr_d;
         memData_q  <= memData_d;
         padded_q   <= padded_d;
         count_q    <= count_d;
         sum_q      <= sum_d;
      end
   end

   assign in_ready   = (state_q == LOAD);
   assign mem_we     = memWe_q;
   assign mem_addr   = memAddr_q;
   assign mem_wdata  = memData_q;
   assign busy       = (state_q == LOAD);
   assign done       = (state_q == DONE);
   assign error      = (state_q == ERROR);
   assign cpu_hold   = (state_q != DONE);
   assign padded     = padded_q;
   assign byte_count = count_q;
   assign checksum   = sum_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: a default-size loader and a 16-byte one
// share the stimulus so the overflow case can be exercised on the small memory.
module tb_instr_mem_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, in_valid, in_last;
   logic [7:0] in_data;

   logic        in_ready, mem_we, busy, done, error, cpu_hold, padded;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [15:0] byte_count;
   logic [7:0]  checksum;

   logic        sReady, sWe, sBusy, sDone, sError, sHold, sPadded;
   logic [3:0]  sAddr;
   logic [31:0] sWdata;
   logic [15:0] sCount;
   logic [7:0]  sSum;

   instr_mem_loader dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold),
      .padded(padded), .byte_count(byte_count), .checksum(checksum)
   );

   instr_mem_loader #(.MEM_SIZE(16)) dutSmall (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(sReady), .mem_we(sWe), .mem_addr(sAddr),
      .mem_wdata(sWdata), .busy(sBusy), .done(sDone), .error(sError), .cpu_hold(sHold),
      .padded(sPadded), .byte_count(sCount), .checksum(sSum)
   );

   int assertCount = 0;
   int failCount   = 0;

   logic [7:0]  prog [8] = '{8'h80, 8'h20, 8'h00, 8'h0A, 8'h04, 8'h40, 8'h08, 8'h00};

   // Write logs captured on the falling edge, away from the DUT update edge.
   int          wrCnt = 0, sWrCnt = 0, dblCnt = 0;
   logic        prevWe = 1'b0, sPrevWe = 1'b0;
   logic [31:0] wrAddr [32];
   logic [31:0] wrData [32];
   logic [31:0] sWrAddr [32];
   logic [31:0] sWrData [32];

   always @(negedge clk) begin
      if (mem_we) begin
         if (wrCnt < 32) begin
            wrAddr[wrCnt] = 32'(mem_addr);
            wrData[wrCnt] = mem_wdata;
         end
         wrCnt++;
         if (prevWe) dblCnt++;
      end
      if (sWe) begin
         if (sWrCnt < 32) begin
            sWrAddr[sWrCnt] = 32'(sAddr);
            sWrData[sWrCnt] = sWdata;
         end
         sWrCnt++;
         if (sPrevWe) dblCnt++;
      end
      prevWe  = mem_we;
      sPrevWe = sWe;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present one byte and hold it until the selected loader accepts it or the budget runs out.
   task automatic applyStimulus(input logic [7:0] d, input logic l, input bit useSmall, output bit acc);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      acc      = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) begin
         acc = useSmall ? sReady : in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic sendByte(input logic [7:0] d, input logic l, input int gap);
      bit acc;
      applyStimulus(d, l, 1'b0, acc);
      checkOutput("byte_accepted", 32'(acc), 32'd1);
      waitCycles(gap);
   endtask

   task automatic pulseStart();
      start = 1'b1;
      waitCycles(1);
      start = 1'b0;
   endtask

   task automatic checkFullLoad();
      checkOutput("full_write_count", wrCnt, 2);
      checkOutput("full_w0_addr", wrAddr[0], 32'h0);
      checkOutput("full_w0_data", wrData[0], 32'h8020000A);
      checkOutput("full_w1_addr", wrAddr[1], 32'h4);
      checkOutput("full_w1_data", wrData[1], 32'h04400800);
      checkOutput("full_done", 32'(done), 32'd1);
      checkOutput("full_cpu_hold", 32'(cpu_hold), 32'd0);
      checkOutput("full_in_ready", 32'(in_ready), 32'd0);
      checkOutput("full_byte_count", 32'(byte_count), 32'd8);
      checkOutput("full_checksum", 32'(checksum), 32'hF6);
      checkOutput("full_padded", 32'(padded), 32'd0);
      checkOutput("full_hold_addr", 32'(mem_addr), 32'h4);
      checkOutput("full_hold_data", mem_wdata, 32'h04400800);
      checkOutput("full_we_low", 32'(mem_we), 32'd0);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'd0);
      checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
      checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_done"}, 32'(done), 32'd0);
      checkOutput({tag, "_error"}, 32'(error), 32'd0);
      checkOutput({tag, "_padded"}, 32'(padded), 32'd0);
      checkOutput({tag, "_byte_count"}, 32'(byte_count), 32'd0);
      checkOutput({tag, "_checksum"}, 32'(checksum), 32'd0);
      checkOutput({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
   endtask

   initial begin
      bit acc;
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
      waitCycles(3);
      checkResetState("rst");
      rst = 1'b0;
      waitCycles(1);

      // Full two-word image, bytes back to back.
      wrCnt = 0;
      pulseStart();
      checkOutput("t1_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 8; i++) sendByte(prog[i], i == 7, 0);
      waitCycles(2);
      checkFullLoad();

      // Restart from DONE, then a short image with a stray start mid-load.
      wrCnt = 0;
      pulseStart();
      checkOutput("restart_busy", 32'(busy), 32'd1);
      checkOutput("restart_count", 32'(byte_count), 32'd0);
      checkOutput("restart_checksum", 32'(checksum), 32'd0);
      checkOutput("restart_cpu_hold", 32'(cpu_hold), 32'd1);
      checkOutput("restart_done", 32'(done), 32'd0);
      sendByte(prog[0], 1'b0, 0);
      sendByte(prog[1], 1'b0, 0);
      pulseStart();
      checkOutput("midstart_count", 32'(byte_count), 32'd2);
      for (int i = 2; i < 6; i++) sendByte(prog[i], i == 5, 0);
      waitCycles(2);
      checkOutput("part_write_count", wrCnt, 2);
      checkOutput("part_w0_addr", wrAddr[0], 32'h0);
      checkOutput("part_w0_data", wrData[0], 32'h8020000A);
      checkOutput("part_w1_addr", wrAddr[1], 32'h4);
      checkOutput("part_w1_data", wrData[1], 32'h04400000);
      checkOutput("part_padded", 32'(padded), 32'd1);
      checkOutput("part_count", 32'(byte_count), 32'd6);
      checkOutput("part_checksum", 32'(checksum), 32'hEE);
      checkOutput("part_done", 32'(done), 32'd1);

      // Same image with three idle cycles between bytes.
      wrCnt = 0;
      dblCnt = 0;
      pulseStart();
      for (int i = 0; i < 8; i++) begin
         sendByte(prog[i], i == 7, 3);
         if (i == 2) checkOutput("gap_no_early_write", wrCnt, 0);
         if (i == 3) checkOutput("gap_first_write", wrCnt, 1);
         if (i == 6) checkOutput("gap_no_mid_write", wrCnt, 1);
      end
      checkFullLoad();
      checkOutput("gap_single_strobe", dblCnt, 0);

      // Reset during a load, colliding with a byte handshake.
      wrCnt = 0;
      pulseStart();
      for (int i = 0; i < 3; i++) sendByte(prog[i], 1'b0, 0);
      in_valid = 1'b1;
      in_data  = prog[3];
      rst      = 1'b1;
      waitCycles(1);
      in_valid = 1'b0;
      checkResetState("midrst");
      waitCycles(1);
      checkResetState("midrst_hold");
      rst = 1'b0;
      waitCycles(1);
      checkOutput("midrst_no_write", wrCnt, 0);
      checkOutput("midrst_idle_busy", 32'(busy), 32'd0);
      pulseStart();
      for (int i = 0; i < 8; i++) sendByte(prog[i], i == 7, 0);
      waitCycles(2);
      checkFullLoad();

      // Overflow on the 16-byte loader: 17 bytes offered, no last.
      sWrCnt = 0;
      pulseStart();
      for (int i = 0; i < 16; i++) begin
         applyStimulus(8'(i + 1), 1'b0, 1'b1, acc);
         checkOutput("ovf_byte_accepted", 32'(acc), 32'd1);
      end
      waitCycles(1);
      checkOutput("ovf_error_after_write", 32'(sError), 32'd1);
      applyStimulus(8'h11, 1'b0, 1'b1, acc);
      checkOutput("ovf_17th_rejected", 32'(acc), 32'd0);
      checkOutput("ovf_write_count", sWrCnt, 4);
      checkOutput("ovf_w0_addr", sWrAddr[0], 32'h0);
      checkOutput("ovf_w0_data", sWrData[0], 32'h01020304);
      checkOutput("ovf_w1_addr", sWrAddr[1], 32'h4);
      checkOutput("ovf_w2_addr", sWrAddr[2], 32'h8);
      checkOutput("ovf_w3_addr", sWrAddr[3], 32'hC);
      checkOutput("ovf_w3_data", sWrData[3], 32'h0D0E0F10);
      checkOutput("ovf_error", 32'(sError), 32'd1);
      checkOutput("ovf_in_ready", 32'(sReady), 32'd0);
      checkOutput("ovf_count", 32'(sCount), 32'd16);
      checkOutput("ovf_checksum", 32'(sSum), 32'h88);
      checkOutput("ovf_done", 32'(sDone), 32'd0);
      checkOutput("ovf_cpu_hold", 32'(sHold), 32'd1);
      checkOutput("any_double_strobe", dblCnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
